// File: rtl/phase_arbiter.sv
// phase_arbiter
//   Demand-driven phase scheduler for the Thevenin/Norton intersection.
//   Sensor requests are synchronised and latched. Green is granted to one
//   phase at a time in round-robin order, with min/max green, yellow and
//   all-red clearance. All timing advances on the one-cycle 'tick' pulse.
//
// Ports
//   clk          system clock
//   clock_reset  synchronous active-high reset (all red, phase 2)
//   tick         one-clk timing pulse
//   STH/SNN/SNS  asynchronous vehicle sensors (2-flop synchronised here)
//   Semaforo_*   straight light codes   (00 red, 01 green, 10 yellow)
//   Giro_*       arrow light codes      (00 red, 01 green; never yellow)
//   phase        current phase index
//   ped_btn      pedestrian request     (PHASE_ARB_PED_EN only)
//   ped_walk     walk lamp              (PHASE_ARB_PED_EN only)
//
// Build option: define PHASE_ARB_PED_EN to add the pedestrian phase P3.
module phase_arbiter #(
    parameter int MIN_GREEN = 8,
    parameter int MAX_GREEN = 30,
    parameter int YELLOW_T  = 3,
    parameter int ALL_RED_T = 2,
    parameter int WALK_T    = 10
) (
    input  logic       clk,
    input  logic       clock_reset,
    input  logic       tick,
    input  logic       STH,
    input  logic       SNN,
    input  logic       SNS,
    output logic [1:0] Semaforo_TH,
    output logic [1:0] Semaforo_NN,
    output logic [1:0] Semaforo_NS,
    output logic [1:0] Giro_TH_izq,
    output logic [1:0] Giro_NN_izq,
    output logic [1:0] Giro_NN_der,
    output logic [1:0] phase
`ifdef PHASE_ARB_PED_EN
    ,
    input  logic       ped_btn,
    output logic       ped_walk
`endif
);

`ifdef PHASE_ARB_PED_EN
    localparam int NREQ = 4;
`else
    localparam int NREQ = 3;
`endif

    // A max below the min simply degenerates to the min.
    localparam int MAX_EFF = (MAX_GREEN < MIN_GREEN) ? MIN_GREEN : MAX_GREEN;

    localparam logic [8:0] MIN_G9     = 9'(MIN_GREEN);
    localparam logic [8:0] MAX_G9     = 9'(MAX_EFF);
    localparam logic [8:0] YELLOW_G9  = 9'(YELLOW_T);
    localparam logic [8:0] ALL_RED_G9 = 9'(ALL_RED_T);
    localparam logic [8:0] WALK_G9    = 9'(WALK_T);

    localparam logic [1:0] CODE_RED    = 2'b00;
    localparam logic [1:0] CODE_GREEN  = 2'b01;
    localparam logic [1:0] CODE_YELLOW = 2'b10;

    typedef enum logic [1:0] {
        ST_GREEN   = 2'd0,
        ST_YELLOW  = 2'd1,
        ST_ALL_RED = 2'd2
    } state_e;

    state_e          state_r, state_nxt_s;
    logic [1:0]      phase_r, phase_nxt_s, next_phase_s;
    logic [7:0]      timer_r, timer_nxt_s;
    logic [8:0]      timer_inc_s;
    logic [NREQ-1:0] req_r, req_nxt_s, req_set_s, phase_mask_s, next_mask_s;
    logic [1:0]      sth_sync_r, snn_sync_r, sns_sync_r;
    logic            sth_s, snn_s, sns_s;
    logic            own_sensor_s, other_req_s, go_yellow_s, enter_green_s;
    logic [1:0]      th_r, nn_r, ns_r, th_izq_r, nn_izq_r, nn_der_r;
    logic [1:0]      th_nxt_s, nn_nxt_s, ns_nxt_s, th_izq_nxt_s, nn_izq_nxt_s, nn_der_nxt_s;
`ifdef PHASE_ARB_PED_EN
    logic [1:0]      ped_sync_r;
    logic            walk_r, walk_nxt_s;
`endif

    // First requested phase strictly after 'cur' in cyclic order; the current
    // phase itself is considered last; no request at all selects P0.
    function automatic logic [1:0] pick_next(input logic [1:0] cur, input logic [NREQ-1:0] req);
        logic [1:0] sel;
        logic [1:0] idx;
        sel = 2'd0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = 2'((int'(cur) + k) % NREQ);
            sel = req[idx] ? idx : sel;
        end
        return sel;
    endfunction

    assign sth_s = sth_sync_r[1];
    assign snn_s = snn_sync_r[1];
    assign sns_s = sns_sync_r[1];

    // Two-flop synchronisers for the asynchronous request inputs.
    always_ff @(posedge clk) begin
        if (clock_reset) begin
            sth_sync_r <= 2'b00;
            snn_sync_r <= 2'b00;
            sns_sync_r <= 2'b00;
`ifdef PHASE_ARB_PED_EN
            ped_sync_r <= 2'b00;
`endif
        end else begin
            sth_sync_r <= {sth_sync_r[0], STH};
            snn_sync_r <= {snn_sync_r[0], SNN};
            sns_sync_r <= {sns_sync_r[0], SNS};
`ifdef PHASE_ARB_PED_EN
            ped_sync_r <= {ped_sync_r[0], ped_btn};
`endif
        end
    end

    // Demand decode, own-sensor selection and green exit condition.
    always_comb begin
        req_set_s    = {NREQ{1'b0}};
        req_set_s[0] = sth_s;
        req_set_s[1] = snn_s | sns_s;
        req_set_s[2] = snn_s;
`ifdef PHASE_ARB_PED_EN
        req_set_s[3] = ped_sync_r[1];
`endif
        phase_mask_s = {{(NREQ-1){1'b0}}, 1'b1} << phase_r;
        other_req_s  = |(req_r & ~phase_mask_s);
        next_phase_s = pick_next(phase_r, req_r);
        timer_inc_s  = {1'b0, timer_r} + 9'd1;
        case (phase_r)
            2'd0:    own_sensor_s = sth_s;
            2'd1:    own_sensor_s = snn_s | sns_s;
            2'd2:    own_sensor_s = snn_s;
            default: own_sensor_s = 1'b0;
        endcase
        // The walk phase has a fixed length: no extension, no early exit.
        if (phase_r == 2'd3) begin
            go_yellow_s = (timer_inc_s >= WALK_G9);
        end else begin
            go_yellow_s = (timer_inc_s >= MIN_G9) && other_req_s &&
                          (!own_sensor_s || (timer_inc_s >= MAX_G9));
        end
    end

    // Next-state logic: state only moves on a tick; timer zeroes on each entry.
    always_comb begin
        state_nxt_s   = state_r;
        phase_nxt_s   = phase_r;
        timer_nxt_s   = timer_r;
        enter_green_s = 1'b0;
        if (tick) begin
            timer_nxt_s = (timer_r == 8'hFF) ? 8'hFF : timer_inc_s[7:0];
            case (state_r)
                ST_GREEN: begin
                    if (go_yellow_s) begin
                        state_nxt_s = ST_YELLOW;
                        timer_nxt_s = 8'd0;
                    end else begin
                        state_nxt_s = ST_GREEN;
                    end
                end
                ST_YELLOW: begin
                    if (timer_inc_s >= YELLOW_G9) begin
                        state_nxt_s = ST_ALL_RED;
                        timer_nxt_s = 8'd0;
                    end else begin
                        state_nxt_s = ST_YELLOW;
                    end
                end
                ST_ALL_RED: begin
                    if (timer_inc_s >= ALL_RED_G9) begin
                        state_nxt_s   = ST_GREEN;
                        phase_nxt_s   = next_phase_s;
                        timer_nxt_s   = 8'd0;
                        enter_green_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_ALL_RED;
                    end
                end
                default: begin
                    state_nxt_s = ST_ALL_RED;
                    timer_nxt_s = 8'd0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Request latches: the granted phase's clear wins over a same-cycle set.
    always_comb begin
        next_mask_s = {{(NREQ-1){1'b0}}, 1'b1} << phase_nxt_s;
        if (enter_green_s) begin
            req_nxt_s = (req_r | req_set_s) & ~next_mask_s;
        end else begin
            req_nxt_s = req_r | req_set_s;
        end
    end

    // Light decode from the next state so the registered lamps move with it.
    always_comb begin
        th_nxt_s     = CODE_RED;
        nn_nxt_s     = CODE_RED;
        ns_nxt_s     = CODE_RED;
        th_izq_nxt_s = CODE_RED;
        nn_izq_nxt_s = CODE_RED;
        nn_der_nxt_s = CODE_RED;
`ifdef PHASE_ARB_PED_EN
        walk_nxt_s   = 1'b0;
`endif
        case (state_nxt_s)
            ST_GREEN: begin
                case (phase_nxt_s)
                    2'd0: begin
                        th_nxt_s     = CODE_GREEN;
                        th_izq_nxt_s = CODE_GREEN;
                    end
                    2'd1: begin
                        nn_nxt_s = CODE_GREEN;
                        ns_nxt_s = CODE_GREEN;
                    end
                    2'd2: begin
                        nn_izq_nxt_s = CODE_GREEN;
                        nn_der_nxt_s = CODE_GREEN;
                    end
`ifdef PHASE_ARB_PED_EN
                    2'd3: walk_nxt_s = 1'b1;
`endif
                    default: th_nxt_s = CODE_RED;
                endcase
            end
            // Arrows go straight from green to red; only straights show yellow.
            ST_YELLOW: begin
                case (phase_nxt_s)
                    2'd0:    th_nxt_s = CODE_YELLOW;
                    2'd1: begin
                        nn_nxt_s = CODE_YELLOW;
                        ns_nxt_s = CODE_YELLOW;
                    end
                    default: th_nxt_s = CODE_RED;
                endcase
            end
            default: th_nxt_s = CODE_RED;
        endcase
    end

    // FSM state, phase, tick timer and demand latches.
    always_ff @(posedge clk) begin
        if (clock_reset) begin
            state_r <= ST_ALL_RED;
            phase_r <= 2'd2;
            timer_r <= 8'd0;
            req_r   <= {NREQ{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            phase_r <= phase_nxt_s;
            timer_r <= timer_nxt_s;
            req_r   <= req_nxt_s;
        end
    end

    // Registered lamp outputs.
    always_ff @(posedge clk) begin
        if (clock_reset) begin
            th_r     <= CODE_RED;
            nn_r     <= CODE_RED;
            ns_r     <= CODE_RED;
            th_izq_r <= CODE_RED;
            nn_izq_r <= CODE_RED;
            nn_der_r <= CODE_RED;
`ifdef PHASE_ARB_PED_EN
            walk_r   <= 1'b0;
`endif
        end else begin
            th_r     <= th_nxt_s;
            nn_r     <= nn_nxt_s;
            ns_r     <= ns_nxt_s;
            th_izq_r <= th_izq_nxt_s;
            nn_izq_r <= nn_izq_nxt_s;
            nn_der_r <= nn_der_nxt_s;
`ifdef PHASE_ARB_PED_EN
            walk_r   <= walk_nxt_s;
`endif
        end
    end

    assign Semaforo_TH = th_r;
    assign Semaforo_NN = nn_r;
    assign Semaforo_NS = ns_r;
    assign Giro_TH_izq = th_izq_r;
    assign Giro_NN_izq = nn_izq_r;
    assign Giro_NN_der = nn_der_r;
    assign phase       = phase_r;
`ifdef PHASE_ARB_PED_EN
    assign ped_walk    = walk_r;
`endif

endmodule

// File: tb/tb_phase_arbiter.sv
// tb_phase_arbiter
//   Self-checking bench for phase_arbiter (MIN_GREEN=4, MAX_GREEN=10,
//   YELLOW_T=2, ALL_RED_T=1, WALK_T=3, tick every 4 clk). Each tick pushes
//   the expected light vector {phase, TH, NN, NS, TH_izq, NN_izq, NN_der,
//   walk} into a scoreboard queue; it is popped and compared one clk later,
//   and the vector must then hold steady until the next tick.
//   Define PHASE_ARB_PED_EN to also exercise the pedestrian phase.
module tb_phase_arbiter;

    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] G = 2'b01;
    localparam logic [1:0] Y = 2'b10;

    logic       clk = 1'b0;
    logic       clock_reset = 1'b1;
    logic       tick = 1'b0;
    logic       STH = 1'b0, SNN = 1'b0, SNS = 1'b0;
    logic [1:0] Semaforo_TH, Semaforo_NN, Semaforo_NS;
    logic [1:0] Giro_TH_izq, Giro_NN_izq, Giro_NN_der, phase;
    logic       walk_obs;
    logic [14:0] obs_s;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [14:0] sb_q[$];
    logic [14:0] last_exp;
    logic [14:0] p0g, p0y, p1g, p1y, p2g, p2y, p3g, p3y, ar0, ar1, ar2, ar3;

`ifdef PHASE_ARB_PED_EN
    logic ped_btn = 1'b0;
    logic ped_walk;
`endif

    phase_arbiter #(
        .MIN_GREEN(4), .MAX_GREEN(10), .YELLOW_T(2), .ALL_RED_T(1), .WALK_T(3)
    ) dut (
        .clk(clk),
        .clock_reset(clock_reset),
        .tick(tick),
        .STH(STH),
        .SNN(SNN),
        .SNS(SNS),
        .Semaforo_TH(Semaforo_TH),
        .Semaforo_NN(Semaforo_NN),
        .Semaforo_NS(Semaforo_NS),
        .Giro_TH_izq(Giro_TH_izq),
        .Giro_NN_izq(Giro_NN_izq),
        .Giro_NN_der(Giro_NN_der),
        .phase(phase)
`ifdef PHASE_ARB_PED_EN
        ,
        .ped_btn(ped_btn),
        .ped_walk(ped_walk)
`endif
    );

`ifdef PHASE_ARB_PED_EN
    assign walk_obs = ped_walk;
`else
    assign walk_obs = 1'b0;
`endif
    assign obs_s = {phase, Semaforo_TH, Semaforo_NN, Semaforo_NS,
                    Giro_TH_izq, Giro_NN_izq, Giro_NN_der, walk_obs};

    // 10-unit clock.
    always #5 clk = ~clk;

    function automatic logic [14:0] lights(input logic [1:0] ph, input logic [1:0] th,
                                           input logic [1:0] nn, input logic [1:0] ns,
                                           input logic [1:0] thl, input logic [1:0] nnl,
                                           input logic [1:0] nnr, input logic walk);
        return {ph, th, nn, ns, thl, nnl, nnr, walk};
    endfunction

    task automatic check_val(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Called on a negedge: pulse tick for one clk, score the result, then
    // confirm the lamps stay put for the remaining three clocks.
    task automatic tick_step(input logic [14:0] exp, input string tag);
        logic [14:0] want;
        tick = 1'b1;
        sb_q.push_back(exp);
        @(negedge clk);
        tick = 1'b0;
        want = sb_q.pop_front();
        check_val(tag, obs_s, want);
        last_exp = want;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val({tag, "_hold"}, obs_s, last_exp);
        end
    endtask

    task automatic do_reset();
        clock_reset = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check_val("reset_state", obs_s, ar2);
        @(negedge clk);
        clock_reset = 1'b0;
        last_exp = ar2;
    endtask

    initial begin
        p0g = lights(2'd0, G, R, R, G, R, R, 1'b0);
        p0y = lights(2'd0, Y, R, R, R, R, R, 1'b0);
        p1g = lights(2'd1, R, G, G, R, R, R, 1'b0);
        p1y = lights(2'd1, R, Y, Y, R, R, R, 1'b0);
        p2g = lights(2'd2, R, R, R, R, G, G, 1'b0);
        ar0 = lights(2'd0, R, R, R, R, R, R, 1'b0);
        ar1 = lights(2'd1, R, R, R, R, R, R, 1'b0);
        ar2 = lights(2'd2, R, R, R, R, R, R, 1'b0);
        ar3 = lights(2'd3, R, R, R, R, R, R, 1'b0);
        p2y = ar2;
        p3g = lights(2'd3, R, R, R, R, R, R, 1'b1);
        p3y = ar3;

        // 1: no demand -> one tick of all red, then P0 rests in green.
        do_reset();
        tick_step(p0g, "t1_first_green");
        repeat (7) tick_step(p0g, "t1_rest");

        // 2: SNS pulse in P0 -> 4 ticks green, 2 yellow, 1 all-red, P1.
        do_reset();
        tick_step(p0g, "t2_green");
        SNS = 1'b1;
        tick_step(p0g, "t2_green");
        SNS = 1'b0;
        repeat (2) tick_step(p0g, "t2_green");
        repeat (2) tick_step(p0y, "t2_yellow");
        tick_step(ar0, "t2_allred");
        tick_step(p1g, "t2_p1_green");

        // 3: P1 held by its own sensors, capped at 10 ticks of green.
        SNN = 1'b1; SNS = 1'b1; STH = 1'b1;
        tick_step(p1g, "t3_p1_green");
        STH = 1'b0;
        repeat (8) tick_step(p1g, "t3_p1_green");
        SNN = 1'b0; SNS = 1'b0;
        repeat (2) tick_step(p1y, "t3_p1_yellow");
        tick_step(ar1, "t3_allred");
        tick_step(p2g, "t3_p2_green");

        // 4: P2 then back to P0 (STH latched), then P1; later P2 -> P1 skips P0.
        repeat (3) tick_step(p2g, "t4_p2_green");
        repeat (2) tick_step(p2y, "t4_p2_yellow");
        tick_step(ar2, "t4_allred2");
        repeat (4) tick_step(p0g, "t4_p0_green");
        repeat (2) tick_step(p0y, "t4_p0_yellow");
        tick_step(ar0, "t4_allred0");
        repeat (6) tick_step(p1g, "t4_p1_rest");
        SNN = 1'b1;
        tick_step(p1g, "t4_p1_green");
        SNN = 1'b0;
        tick_step(p1g, "t4_p1_green");
        repeat (2) tick_step(p1y, "t4_p1_yellow");
        tick_step(ar1, "t4_allred1");
        repeat (4) tick_step(p2g, "t4_p2_green");
        tick_step(p2y, "t4_p2_yellow");

        // 5: reset in yellow with P1 still requested -> all red now, P0 next.
        clock_reset = 1'b1;
        @(negedge clk);
        check_val("t5_reset_in_yellow", obs_s, ar2);
        @(negedge clk);
        clock_reset = 1'b0;
        last_exp = ar2;
        tick_step(p0g, "t5_req_cleared");
        tick_step(p0g, "t5_p0_rest");

`ifdef PHASE_ARB_PED_EN
        // 6: pedestrian request -> walk for exactly 3 ticks, vehicles red.
        do_reset();
        tick_step(p0g, "t6_green");
        ped_btn = 1'b1;
        tick_step(p0g, "t6_green");
        ped_btn = 1'b0;
        repeat (2) tick_step(p0g, "t6_green");
        repeat (2) tick_step(p0y, "t6_yellow");
        tick_step(ar0, "t6_allred0");
        repeat (3) tick_step(p3g, "t6_walk");
        repeat (2) tick_step(p3y, "t6_walk_yellow");
        tick_step(ar3, "t6_allred3");
        tick_step(p0g, "t6_back_p0");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
